tone_gen: RTL

Note player that sits directly downstream of one microcontroller output register. It turns the 8-bit note byte and the 8-bit duration byte written by the program into a square wave for the piano speaker, timed in millisecond ticks. It reports `playing` and a one-cycle `done` so that the status can be routed back to a microcontroller input port.

---
 rtl/tone_pkg.sv | 54 +++++
 rtl/tone_div.sv | 51 +++++
 rtl/tone_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tone_pkg.sv
// ----------------------------------------------------------------------------
// tone_pkg: shared types and constants for the tone_gen note player.
//   - state_e      : player FSM states (ST_GAP only with TONE_GAP_EN defined)
//   - SEMI_*       : semitone codes C..B and the rest code
//   - FREQ_CHZ     : octave-0 note frequencies C0..B0 in centihertz
//   - half_table() : constant function giving octave-0 half-periods in clock
//                    cycles, CLK_HZ / (2 * f), truncated
//   - HALF_TBL     : the table evaluated for the default 50 MHz clock
// Configuration macro: TONE_GAP_EN adds the articulation GAP state.
// ----------------------------------------------------------------------------
package tone_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1
`ifdef TONE_GAP_EN
        , ST_GAP = 2'd2
`endif
    } state_e;

    localparam logic [3:0] SEMI_C    = 4'd0;
    localparam logic [3:0] SEMI_CS   = 4'd1;
    localparam logic [3:0] SEMI_D    = 4'd2;
    localparam logic [3:0] SEMI_DS   = 4'd3;
    localparam logic [3:0] SEMI_E    = 4'd4;
    localparam logic [3:0] SEMI_F    = 4'd5;
    localparam logic [3:0] SEMI_FS   = 4'd6;
    localparam logic [3:0] SEMI_G    = 4'd7;
    localparam logic [3:0] SEMI_GS   = 4'd8;
    localparam logic [3:0] SEMI_A    = 4'd9;
    localparam logic [3:0] SEMI_AS   = 4'd10;
    localparam logic [3:0] SEMI_B    = 4'd11;
    localparam logic [3:0] SEMI_REST = 4'd12;   // 12..15 all decode as rest

    typedef int unsigned half_tbl_t [0:11];

    // C0..B0 in centihertz (16.35 Hz .. 30.87 Hz).
    localparam half_tbl_t FREQ_CHZ = '{
        1635, 1732, 1835, 1945, 2060, 2183,
        2312, 2450, 2596, 2750, 2914, 3087
    };

    function automatic half_tbl_t half_table(input logic [63:0] clk_hz);
        half_tbl_t tbl;
        for (int i = 0; i < 12; i++) begin
            tbl[i] = 32'((clk_hz * 64'd100) / (64'd2 * 64'(FREQ_CHZ[i])));
        end
        return tbl;
    endfunction

    localparam logic [63:0] DEF_CLK_HZ = 64'd50_000_000;
    localparam half_tbl_t   HALF_TBL   = half_table(DEF_CLK_HZ);

endpackage

// File: rtl/tone_div.sv
// ----------------------------------------------------------------------------
// tone_div: loadable half-period down-counter with a toggling square output.
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   load_i  in   load half_i as reload value and count, force spk_o low
//   half_i  in   half-period in clock cycles
//   run_i   in   count down; at 1 reload and toggle spk_o
//   spk_o   out  square wave; forced low whenever neither load nor run
// ----------------------------------------------------------------------------
module tone_div #(
    parameter int HP_W = 21
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [HP_W-1:0] half_i,
    input  logic            run_i,
    output logic            spk_o
);

    logic [HP_W-1:0] half_q;
    logic [HP_W-1:0] cnt_q;
    logic            spk_q;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            half_q <= '0;
            cnt_q  <= '0;
            spk_q  <= 1'b0;
        end else if (load_i) begin
            half_q <= half_i;
            cnt_q  <= half_i;
            spk_q  <= 1'b0;
        end else if (run_i) begin
            // Reloading at 1 (not 0) makes each output phase exactly half_q cycles.
            if (cnt_q == HP_W'(1)) begin
                cnt_q <= half_q;
                spk_q <= ~spk_q;
            end else begin
                cnt_q <= cnt_q - HP_W'(1);
            end
        end else begin
            spk_q <= 1'b0;
        end
    end

    assign spk_o = spk_q;

endmodule

// File: rtl/tone_gen.sv
// ----------------------------------------------------------------------------
// tone_gen: note player driven by a microcontroller note/duration register.
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-low reset
//   note_in  in   [7] gate, [6:4] octave, [3:0] semitone (12..15 = rest)
//   dur_in   in   duration in ticks, 0 = sustain while gated
//   spk      out  square-wave speaker drive
//   playing  out  high while a note, rest (or gap) is active
//   done     out  one-cycle pulse when a timed duration expires
// Configuration macro: TONE_GAP_EN -- a retrigger from PLAY first spends one
// silent tick in GAP so repeated notes are articulated.
// ----------------------------------------------------------------------------
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1000,
    parameter int          HP_W    = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] note_in,
    input  logic [7:0] dur_in,
    output logic       spk,
    output logic       playing,
    output logic       done
);

    localparam int unsigned PRE_DIV = CLK_HZ / TICK_HZ;
    localparam int          PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    // NOTE: the table is a constant, not storage, so it needs no reset.
    localparam half_tbl_t   HP_TBL  = half_table(64'(CLK_HZ));

    state_e           state_q;
    logic [7:0]       note_q;
    logic             arm_q;
    logic [7:0]       dur_q;
    logic             rest_q;
    logic [PRE_W-1:0] pre_q;
    logic [7:0]       tick_q;
    logic             playing_q;
    logic             done_q;

    logic             trigger;
    logic             gate_off;
    logic             tick_now;
    logic             expire;
    logic             div_run;
    logic [3:0]       semi_idx;
    logic [HP_W-1:0]  hp_load;

    // arm_q blocks the first cycle after reset so a stale non-zero note_in is
    // only sampled, never replayed.
    assign trigger  = arm_q && (note_in != note_q) && note_in[7];
    assign gate_off = !note_in[7];
    assign tick_now = (pre_q == PRE_W'(PRE_DIV - 1));
    assign expire   = (state_q == ST_PLAY) && (dur_q != 8'd0) && tick_now &&
                      ((tick_q + 8'd1) == dur_q);

    // Stop the divider on the same edge the FSM leaves PLAY so spk is already
    // low in the first IDLE cycle.
    assign div_run  = (state_q == ST_PLAY) && !rest_q && !gate_off && !expire;

    assign semi_idx = (note_in[3:0] > SEMI_B) ? SEMI_C : note_in[3:0];
    assign hp_load  = HP_W'(HP_TBL[semi_idx] >> note_in[6:4]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            note_q    <= 8'd0;
            arm_q     <= 1'b0;
            dur_q     <= 8'd0;
            rest_q    <= 1'b0;
            pre_q     <= '0;
            tick_q    <= 8'd0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            note_q <= note_in;
            arm_q  <= 1'b1;
            done_q <= 1'b0;
            // Priority: trigger, then gate-off, then expiry.
            if (trigger) begin
                dur_q     <= dur_in;
                rest_q    <= (note_in[3:0] >= SEMI_REST);
                pre_q     <= '0;
                tick_q    <= 8'd0;
                playing_q <= 1'b1;
`ifdef TONE_GAP_EN
                state_q   <= (state_q == ST_PLAY) ? ST_GAP : ST_PLAY;
`else
                state_q   <= ST_PLAY;
`endif
            end else if (gate_off) begin
                state_q   <= ST_IDLE;
                playing_q <= 1'b0;
                pre_q     <= '0;
                tick_q    <= 8'd0;
            end else begin
                case (state_q)
                    ST_PLAY: begin
                        if (expire) begin
                            state_q   <= ST_IDLE;
                            playing_q <= 1'b0;
                            done_q    <= 1'b1;
                            pre_q     <= '0;
                            tick_q    <= 8'd0;
                        end else if (tick_now) begin
                            pre_q  <= '0;
                            tick_q <= tick_q + 8'd1;
                        end else begin
                            pre_q <= pre_q + PRE_W'(1);
                        end
                    end
`ifdef TONE_GAP_EN
                    ST_GAP: begin
                        pre_q <= tick_now ? '0 : pre_q + PRE_W'(1);
                        if (tick_now) begin
                            state_q <= ST_PLAY;
                            tick_q  <= 8'd0;
                        end
                    end
`endif
                    default: begin
                        pre_q  <= '0;
                        tick_q <= 8'd0;
                    end
                endcase
            end
        end
    end

    tone_div #(
        .HP_W (HP_W)
    ) u_div (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (trigger),
        .half_i (hp_load),
        .run_i  (div_run),
        .spk_o  (spk)
    );

    assign playing = playing_q;
    assign done    = done_q;

endmodule
